// File: rtl/uart_modem_ctrl_if.sv
// uart_modem_ctrl_if
//   Register-side and pin-side signals of the modem status/control block.
//   The block itself connects through the slave modport; whatever drives it
//   (register file, pads, testbench) uses the master modport.
//
//   in_ni        modem inputs, active-low, asynchronous
//   out_no       modem outputs, active-low, registered
//   ctrl_out_i   output control bits, active-high (RTS, DTR, ...)
//   loopback_i   internal loopback enable
//   edge_mode_i  per channel [2i+1:2i]: 00 any, 01 rise, 10 fall, 11 off
//   filter_len_i stable cycles required before the filtered level changes
//   rd_clr_i     status read strobe, clears sticky event bits
//   irq_en_i     per-channel interrupt enable
//   status_o     filtered input level, active-high
//   delta_o      sticky event bits
//   irq_o        registered interrupt request
interface uart_modem_ctrl_if #(
  parameter int NrInputs    = 4,
  parameter int NrOutputs   = 2,
  parameter int FilterWidth = 4
);
  logic [NrInputs-1:0]    in_ni;
  logic [NrOutputs-1:0]   out_no;
  logic [NrOutputs-1:0]   ctrl_out_i;
  logic                   loopback_i;
  logic [2*NrInputs-1:0]  edge_mode_i;
  logic [FilterWidth-1:0] filter_len_i;
  logic                   rd_clr_i;
  logic [NrInputs-1:0]    irq_en_i;
  logic [NrInputs-1:0]    status_o;
  logic [NrInputs-1:0]    delta_o;
  logic                   irq_o;

  modport slave (
    input  in_ni, ctrl_out_i, loopback_i, edge_mode_i, filter_len_i,
           rd_clr_i, irq_en_i,
    output out_no, status_o, delta_o, irq_o
  );

  modport master (
    output in_ni, ctrl_out_i, loopback_i, edge_mode_i, filter_len_i,
           rd_clr_i, irq_en_i,
    input  out_no, status_o, delta_o, irq_o
  );
endinterface

// File: rtl/uart_modem_ctrl.sv
// uart_modem_ctrl
//   Modem status/control logic for the UART. Each active-low modem input is
//   synchronised, debounced by a programmable glitch filter and classified
//   into sticky event bits that a status read clears. A maskable registered
//   interrupt summarises the events. Also drives registered active-low modem
//   outputs and offers an internal loopback path (outputs -> inputs).
//
//   clk_i  single clock
//   rst_i  synchronous active-high reset
//   bus    uart_modem_ctrl_if.slave (see interface file for signal list)
module uart_modem_ctrl #(
  parameter int NrInputs     = 4,
  parameter int NrOutputs    = 2,
  parameter int NrSyncStages = 2,
  parameter int FilterWidth  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_modem_ctrl_if.slave  bus
);

  // Synchroniser chain, one vector per stage; resets to the inactive level.
  logic [NrInputs-1:0] sync_reg [NrSyncStages];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NrSyncStages; s++) begin
        sync_reg[s] <= '1;
      end
    end else begin
      sync_reg[0] <= bus.in_ni;
      for (int s = 1; s < NrSyncStages; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  // Loopback source: channels with a matching output see that output's
  // active-low level; the rest read as inactive. Bypasses the synchroniser
  // because it is already in this clock domain.
  logic [NrInputs-1:0] lb_src;
  logic [NrInputs-1:0] src;
  logic [NrInputs-1:0] filt_vec;
  logic [NrInputs-1:0] qual_evt;

  genvar gi;
  generate
    for (gi = 0; gi < NrInputs; gi++) begin : g_ch
      logic [FilterWidth-1:0] cnt_reg, cnt_next;
      logic                   filt_reg, filt_next;
      logic                   evt;
      logic                   rise, fall;

      if (gi < NrOutputs) begin : g_lb_out
        assign lb_src[gi] = ~bus.ctrl_out_i[gi];
      end else begin : g_lb_idle
        assign lb_src[gi] = 1'b1;
      end

      assign src[gi] = bus.loopback_i ? lb_src[gi] : sync_reg[NrSyncStages-1][gi];

      // Debounce: the source must differ from the filtered level for
      // filter_len_i+1 consecutive cycles. The >= compare lets a shortened
      // filter length take effect on a count already in progress.
      always_comb begin
        filt_next = filt_reg;
        cnt_next  = cnt_reg;
        evt       = 1'b0;
        if (src[gi] == filt_reg) begin
          cnt_next = '0;
        end else if (cnt_reg >= bus.filter_len_i) begin
          filt_next = src[gi];
          cnt_next  = '0;
          evt       = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          filt_reg <= filt_next;
          cnt_reg  <= cnt_next;
        end
      end

      // filt is active-low, so the new level being 0 means status rose.
      assign rise = evt & ~src[gi];
      assign fall = evt &  src[gi];

      always_comb begin
        qual_evt[gi] = 1'b0;
        case (bus.edge_mode_i[2*gi +: 2])
          2'b00:   qual_evt[gi] = rise | fall;
          2'b01:   qual_evt[gi] = rise;
          2'b10:   qual_evt[gi] = fall;
          default: qual_evt[gi] = 1'b0;
        endcase
      end

      assign filt_vec[gi] = filt_reg;
    end
  endgenerate

  // Sticky events: a new event in the same cycle as a read clear survives.
  logic [NrInputs-1:0]  delta_reg, delta_next;
  logic                 irq_reg, irq_next;
  logic [NrOutputs-1:0] out_reg;

  always_comb begin
    delta_next = (delta_reg & ~{NrInputs{bus.rd_clr_i}}) | qual_evt;
    // Built from the next-state delta so irq_o tracks delta_o cycle for cycle.
    irq_next   = |(delta_next & bus.irq_en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      delta_reg <= '0;
      irq_reg   <= 1'b0;
      out_reg   <= '1;
    end else begin
      delta_reg <= delta_next;
      irq_reg   <= irq_next;
      out_reg   <= bus.loopback_i ? {NrOutputs{1'b1}} : ~bus.ctrl_out_i;
    end
  end

  assign bus.status_o = ~filt_vec;
  assign bus.delta_o  = delta_reg;
  assign bus.irq_o    = irq_reg;
  assign bus.out_no   = out_reg;

endmodule

// File: tb/tb_uart_modem_ctrl.sv
module tb_uart_modem_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  uart_modem_ctrl_if #(.NrInputs(4), .NrOutputs(2), .FilterWidth(4)) bus ();

  uart_modem_ctrl #(
    .NrInputs(4), .NrOutputs(2), .NrSyncStages(2), .FilterWidth(4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Advance n clock edges, then settle 1 time unit past the edge so both
  // driving and sampling happen away from the active edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_read();
    bus.rd_clr_i = 1'b1;
    cyc(1);
    bus.rd_clr_i = 1'b0;
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.in_ni        = 4'b1111;
    bus.ctrl_out_i   = 2'b00;
    bus.loopback_i   = 1'b0;
    bus.edge_mode_i  = 8'h00;
    bus.filter_len_i = 4'd0;
    bus.rd_clr_i     = 1'b0;
    bus.irq_en_i     = 4'b0000;
    cyc(2);
    rst_i = 1'b0;
    cyc(3);

    // Reset / idle
    chk("rst_status", 32'(bus.status_o), 32'h0);
    chk("rst_delta",  32'(bus.delta_o),  32'h0);
    chk("rst_irq",    32'(bus.irq_o),    32'h0);
    chk("rst_out",    32'(bus.out_no),   32'h3);

    // Zero filter length: 3-cycle latency, irq in the same cycle as delta
    bus.irq_en_i = 4'b0001;
    bus.in_ni[0] = 1'b0;
    cyc(2);
    chk("ch0_early",  32'(bus.status_o[0]), 32'h0);
    cyc(1);
    chk("ch0_status", 32'(bus.status_o[0]), 32'h1);
    chk("ch0_delta",  32'(bus.delta_o[0]),  32'h1);
    chk("ch0_irq",    32'(bus.irq_o),       32'h1);
    clear_read();
    chk("ch0_clr",    32'(bus.delta_o),     32'h0);
    chk("ch0_irqclr", 32'(bus.irq_o),       32'h0);

    // filter_len 3: 2-cycle glitch rejected, 5-cycle low accepted at 6 cycles
    bus.filter_len_i = 4'd3;
    bus.in_ni[1] = 1'b0;
    cyc(2);
    bus.in_ni[1] = 1'b1;
    cyc(8);
    chk("glitch_stat", 32'(bus.status_o[1]), 32'h0);
    chk("glitch_dlt",  32'(bus.delta_o[1]),  32'h0);
    bus.in_ni[1] = 1'b0;
    cyc(5);
    chk("ch1_early",  32'(bus.status_o[1]), 32'h0);
    cyc(1);
    chk("ch1_status", 32'(bus.status_o[1]), 32'h1);
    chk("ch1_delta",  32'(bus.delta_o[1]),  32'h1);
    bus.in_ni[1] = 1'b1;
    cyc(8);
    chk("ch1_release", 32'(bus.status_o[1]), 32'h0);
    clear_read();
    chk("ch1_clr",    32'(bus.delta_o),     32'h0);

    // Rising-only edge mode on ch2
    bus.filter_len_i = 4'd0;
    bus.edge_mode_i  = 8'b00_01_00_00;
    bus.in_ni[2] = 1'b0;
    cyc(3);
    chk("ch2_rise",   32'(bus.delta_o[2]),  32'h1);
    clear_read();
    chk("ch2_clr",    32'(bus.delta_o[2]),  32'h0);
    bus.in_ni[2] = 1'b1;
    cyc(4);
    chk("ch2_fallst", 32'(bus.status_o[2]), 32'h0);
    chk("ch2_nofall", 32'(bus.delta_o[2]),  32'h0);

    // Event coincident with a read clear is kept on ch3
    bus.edge_mode_i = 8'h00;
    bus.irq_en_i    = 4'b1001;
    bus.in_ni[3] = 1'b0;
    cyc(3);
    chk("ch3_first",  32'(bus.delta_o[3]),  32'h1);
    bus.in_ni[3] = 1'b1;
    cyc(2);
    bus.rd_clr_i = 1'b1;
    cyc(1);
    bus.rd_clr_i = 1'b0;
    chk("ch3_kept",   32'(bus.delta_o[3]),  32'h1);
    chk("ch3_status", 32'(bus.status_o[3]), 32'h0);
    chk("ch3_irq",    32'(bus.irq_o),       32'h1);
    clear_read();
    chk("ch3_clr",    32'(bus.delta_o),     32'h0);
    chk("ch3_irqclr", 32'(bus.irq_o),       32'h0);

    // Release ch0, then loopback with ctrl_out 01
    bus.in_ni = 4'b1111;
    cyc(4);
    clear_read();
    chk("idle_status", 32'(bus.status_o), 32'h0);
    bus.ctrl_out_i = 2'b01;
    cyc(1);
    chk("out_normal", 32'(bus.out_no),    32'h2);
    bus.loopback_i = 1'b1;
    cyc(1);
    chk("lb_out",     32'(bus.out_no),    32'h3);
    chk("lb_status",  32'(bus.status_o),  32'h1);
    bus.in_ni = 4'b0000;
    cyc(4);
    chk("lb_ignore",  32'(bus.status_o),  32'h1);
    bus.in_ni      = 4'b1111;
    bus.loopback_i = 1'b0;
    cyc(1);
    chk("lb_exit_out", 32'(bus.out_no),   32'h2);

    // Reset in the middle of a filter count
    bus.filter_len_i = 4'd3;
    bus.in_ni[2] = 1'b0;
    cyc(4);
    rst_i = 1'b1;
    cyc(1);
    rst_i = 1'b0;
    chk("mid_rst_st",  32'(bus.status_o), 32'h0);
    chk("mid_rst_dl",  32'(bus.delta_o),  32'h0);
    chk("mid_rst_irq", 32'(bus.irq_o),    32'h0);
    chk("mid_rst_out", 32'(bus.out_no),   32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_modem_ctrl.md
# uart_modem_ctrl

Parametrised modem-status/control block for the UART peripheral, generalising the fixed 4-in/2-out modem logic. It has NrInputs active-low modem inputs. Each input is synchronised, debounced by a programmable glitch filter and edge-classified per channel into sticky event bits that software clears on read. A maskable, registered interrupt summarises the events. It also drives NrOutputs registered active-low modem outputs and provides an internal loopback mode.

## Interface
- NrInputs, 4: number of active-low modem inputs (CTS, DSR, RI, CD order in UART use); 1..16.
- NrOutputs, 2: number of active-low modem outputs (RTS, DTR); 1..NrInputs.
- NrSyncStages, 2: synchroniser flops per input; ≥2.
- FilterWidth, 4: width of the debounce counter and filter_len_i.
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- in_ni  in  NrInputs  asynchronous modem inputs, active-low.
- out_no  out  NrOutputs  modem outputs, active-low, registered.
- ctrl_out_i  in  NrOutputs  output register bits, active-high (MCR RTS/DTR…).
- loopback_i  in  1  loopback enable.
- edge_mode_i  in  2*NrInputs  per channel [2i+1:2i]: 00 any change, 01 rising (deasserted→asserted), 10 falling, 11 disabled.
- filter_len_i  in  FilterWidth  stable cycles required before the filtered level changes.
- rd_clr_i  in  1  status-register read strobe; clears the sticky event bits.
- irq_en_i  in  NrInputs  per-channel interrupt enable.
- status_o  out  NrInputs  filtered input level, active-high (asserted = 1).
- delta_o  out  NrInputs  sticky event bits.
- irq_o  out  1  registered interrupt request.

## Operation
- Source select per channel: if loopback_i=0, the source is in_ni[i] through the NrSyncStages synchroniser. If loopback_i=1, the source is ~ctrl_out_i[i] for i<NrOutputs and 1 (inactive) otherwise. The loopback path bypasses the synchroniser.
- Filter per channel: filt (active-low) and cnt (FilterWidth bits).
  - If source==filt: cnt←0.
  - Else if cnt≥filter_len_i: filt←source, cnt←0, and an event is raised this cycle.
  - Else: cnt←cnt+1.
  - Using ≥ makes a mid-count decrease of filter_len_i take effect immediately.
- status_o[i] = ~filt[i].
- Event classification on a filt update:
  - rise when status goes 0→1, fall when it goes 1→0.
  - Qualified against edge_mode_i: 00 any, 01 rise only, 10 fall only, 11 none.
- delta update: delta[i]←(delta[i] & ~rd_clr_i) | qualified_event[i]. An event coincident with rd_clr_i is kept (set wins); it is never lost.
- irq_o←|(delta_d & irq_en_i). It is registered from the next-state delta.
- out_no←loopback_i ? all-1 : ~ctrl_out_i. Registered, so outputs are inactive in loopback.
- Entering or leaving loopback changes the source. Resulting level changes pass through the filter and raise events normally.

## Timing
- Reset values: sync flops 1, filt all-1, cnt 0, status_o 0, delta_o 0, irq_o 0, out_no all-1.
- Input to status_o/delta_o latency (input stable, loopback off): NrSyncStages + filter_len_i + 1 cycles.
- Loopback latency from ctrl_out_i change: filter_len_i + 1 cycles.
- irq_o follows delta_o set/clear in the same cycle, because both are computed from delta_d.
- ctrl_out_i to out_no latency: 1 cycle. The same applies to loopback_i affecting out_no.
- Glitches shorter than filter_len_i+1 synchronised cycles never change filt.
- A glitch resets cnt when the source returns to filt.
- Counter saturation is impossible: cnt never exceeds filter_len_i.
- rst_i asserted mid-filter or mid-event returns all state to the reset values on the next edge. No event is generated by reset itself.

## Test plan
- Reset, then idle: status_o=0, delta_o=0, irq_o=0, out_no=2'b11.
- filter_len_i=0, edge_mode 00: drive in_ni[0] 1→0. Required: status_o[0]=1 and delta_o[0]=1 exactly 3 cycles later (NrSyncStages=2); irq_o=1 in that same cycle with irq_en_i[0]=1.
- filter_len_i=3: a 2-cycle low pulse on in_ni[1] causes no status or delta change. A 5-cycle low on in_ni[1] sets status_o[1] 2+3+1=6 cycles after the fall.
- edge_mode ch2=01: assert then deassert in_ni[2]. delta_o[2] sets only on assertion. After rd_clr_i the deassert edge leaves delta_o[2]=0.
- rd_clr_i in the same cycle as a new ch3 event: delta_o[3] stays 1. A second rd_clr_i with no event clears delta_o[3] and drops irq_o in the same cycle.
- loopback_i=1, ctrl_out_i=2'b01, filter_len_i=0: out_no=2'b11 after 1 cycle; status_o[0]=1 after 1 cycle; status_o[1] stays 0; in_ni toggles are ignored.
